commit_unit: RTL
================

COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 Parameter QUEUE_DEPTH, default 4, input queue entries (power of two, >=2).
REQ-002 Parameter PRD_W, default 5, physical register address width.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 reset_i  input  1  asynchronous, active-low reset.
REQ-005 commit_valid_i  input  1  retiring entry presented by the reorder buffer.
REQ-006 commit_ready_o  output  1  unit can accept an entry this cycle.
REQ-007 commit_inst_i  input  32  retiring instruction word.
REQ-008 commit_pc_i  input  32  retiring PC.
REQ-009 commit_prd_i  input  PRD_W  destination physical register.
REQ-010 commit_value_i  input  32  result value.
REQ-011 halt_req_i  input  1  external request to stop accepting and drain.
REQ-012 rf_stall_i  input  1  register-file write port busy; blocks pops.
REQ-013 rf_we_o  output  1  register-file write enable.
REQ-014 rf_waddr_o  output  PRD_W  register-file write address.
REQ-015 rf_wdata_o  output  32  register-file write data.
REQ-016 retire_count_o  output  32  count of retired instructions.
REQ-017 last_pc_o  output  32  PC of most recently retired instruction.
REQ-018 halted_o  output  1  unit is in HALTED state.

Function
REQ-019 Circular queue of QUEUE_DEPTH entries {inst, pc, prd, value}; head/tail wrap modulo QUEUE_DEPTH; occupancy count 0..QUEUE_DEPTH.
REQ-020 commit_ready_o = (state==RUN) && (count < QUEUE_DEPTH), from registered state only; no combinational path from any input.
REQ-021 Push on edge where commit_valid_i && commit_ready_o; entry written at tail, tail+1.
REQ-022 Pop on edge where count>0 && !rf_stall_i && state!=HALTED; pushed entry is poppable no earlier than the following edge (no bypass).
REQ-023 Simultaneous push and pop: both occur, count unchanged; at count==QUEUE_DEPTH no push occurs (ready low).
REQ-024 rf_we_o/rf_waddr_o/rf_wdata_o registered: valid for exactly one cycle following the pop edge; rf_we_o=0 in any cycle not following a pop.
REQ-025 Popped entry with prd==0: no write (rf_we_o stays 0), still counted as retired.
REQ-026 Every pop: retire_count_o+1 (wraps 0xFFFFFFFF->0), last_pc_o <= popped pc, same edge as rf outputs update.
REQ-027 States RUN, DRAIN, HALTED.
REQ-028 RUN->DRAIN when halt_req_i sampled high; DRAIN pops remaining entries, accepts none.
REQ-029 DRAIN->HALTED on edge where count becomes 0 (or immediately if count==0 when halt_req_i sampled).
REQ-030 Popped inst equal to 0x00000073 (ECALL) or 0x00100073 (EBREAK), any state: retired (counted, last_pc updated), no rf write, all remaining entries discarded (count<=0), state<=HALTED.
REQ-031 Halt instruction has priority over a same-edge push; the pushed entry is discarded.
REQ-032 HALTED is exited only by reset; halt_req_i is ignored outside RUN.
REQ-033 halted_o = (state==HALTED), registered.

Reset
REQ-034 reset_i low asynchronously forces: state RUN, head=tail=count=0, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, retire_count_o=0, last_pc_o=0, halted_o=0.
REQ-035 commit_ready_o=0 while reset_i low; 1 on first cycle after release.
REQ-036 Reset asserted mid-drain or mid-write aborts the operation; no rf write after reset release without a new push.

Verification
REQ-037 Push {pc=0x100, prd=7, value=0xDEADBEEF}, rf_stall_i=0 -> rf_we_o=1, waddr=7, wdata=0xDEADBEEF two cycles after push edge; retire_count_o=1, last_pc_o=0x100.
REQ-038 rf_stall_i=1, push 5 entries back-to-back -> 4 accepted, commit_ready_o low after 4th; release stall -> 4 writes on consecutive cycles in push order, retire_count_o=4.
REQ-039 Push prd=0 entry -> no rf_we_o pulse, retire_count_o increments by 1.
REQ-040 Queue holds 3 entries, halt_req_i pulsed -> commit_ready_o=0 next cycle, 3 writes, then halted_o=1.
REQ-041 Queue {ADD, EBREAK pc=0x200, ADD} -> 1 write, retire_count_o=2, last_pc_o=0x200, halted_o=1, third entry never written.
REQ-042 retire_count_o preloaded to 0xFFFFFFFF via 2^32-1 retirements (or forced), one retirement -> 0; reset asserted with 2 queued entries -> all outputs 0, no writes after release.

Source files
------------

// File: rtl/commit_unit.sv
// rtl/commit_unit.sv - in-order retirement queue feeding the register-file write port
module commit_unit #(
    parameter int QUEUE_DEPTH = 4,
    parameter int PRD_W       = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             commit_valid_i,
    output logic             commit_ready_o,
    input  logic [31:0]      commit_inst_i,
    input  logic [31:0]      commit_pc_i,
    input  logic [PRD_W-1:0] commit_prd_i,
    input  logic [31:0]      commit_value_i,
    input  logic             halt_req_i,
    input  logic             rf_stall_i,
    output logic             rf_we_o,
    output logic [PRD_W-1:0] rf_waddr_o,
    output logic [31:0]      rf_wdata_o,
    output logic [31:0]      retire_count_o,
    output logic [31:0]      last_pc_o,
    output logic             halted_o
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ready_q, ready_d;
    logic               rf_we_q, rf_we_d;
    logic [PRD_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [31:0]        rf_wdata_q, rf_wdata_d;
    logic [31:0]        retire_count_q, retire_count_d;
    logic [31:0]        last_pc_q, last_pc_d;
    logic               halted_q, halted_d;

    logic [31:0]        inst_mem  [QUEUE_DEPTH];
    logic [31:0]        pc_mem    [QUEUE_DEPTH];
    logic [PRD_W-1:0]   prd_mem   [QUEUE_DEPTH];
    logic [31:0]        value_mem [QUEUE_DEPTH];

    logic               pop_en;
    logic               push_en;
    logic               halt_inst;
    logic [31:0]        head_inst;

    always_comb begin
        state_d        = state_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        rf_we_d        = 1'b0;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        retire_count_d = retire_count_q;
        last_pc_d      = last_pc_q;

        head_inst = inst_mem[head_q];
        pop_en    = (count_q != '0) && !rf_stall_i && (state_q != ST_HALTED);
        halt_inst = pop_en && ((head_inst == INST_ECALL) || (head_inst == INST_EBREAK));
        // A retiring halt instruction squashes any entry arriving on the same edge.
        push_en   = commit_valid_i && ready_q && !halt_inst;

        if (pop_en) begin
            head_d         = head_q + PTR_W'(1);
            retire_count_d = retire_count_q + 32'd1;
            last_pc_d      = pc_mem[head_q];
            rf_waddr_d     = prd_mem[head_q];
            rf_wdata_d     = value_mem[head_q];
            rf_we_d        = !halt_inst && (prd_mem[head_q] != '0);
        end
        if (push_en) begin
            tail_d = tail_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);

        if (halt_inst) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = ST_HALTED;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (halt_req_i) begin
                        state_d = (count_d == '0) ? ST_HALTED : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (count_d == '0) begin
                        state_d = ST_HALTED;
                    end
                end
                default: ;
            endcase
        end

        // Ready is registered from next-state so it stays low throughout reset.
        ready_d  = (state_d == ST_RUN) && (count_d < CNT_W'(QUEUE_DEPTH));
        halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q        <= ST_RUN;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            ready_q        <= 1'b0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            retire_count_q <= '0;
            last_pc_q      <= '0;
            halted_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            ready_q        <= ready_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            retire_count_q <= retire_count_d;
            last_pc_q      <= last_pc_d;
            halted_q       <= halted_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            inst_mem[tail_q]  <= commit_inst_i;
            pc_mem[tail_q]    <= commit_pc_i;
            prd_mem[tail_q]   <= commit_prd_i;
            value_mem[tail_q] <= commit_value_i;
        end
    end

    assign commit_ready_o = ready_q;
    assign rf_we_o        = rf_we_q;
    assign rf_waddr_o     = rf_waddr_q;
    assign rf_wdata_o     = rf_wdata_q;
    assign retire_count_o = retire_count_q;
    assign last_pc_o      = last_pc_q;
    assign halted_o       = halted_q;

endmodule
